riscv_cache_maint: RTL and testbench
====================================

RISCV_CACHE_MAINT -- requirements
Module: riscv_cache_maint

Interface
REQ-001 SHALL have parameter SETS, default 32: number of cache sets; power of two, at least 2.
REQ-002 SHALL have parameter WAYS, default 2: ways per set, at least 1.
REQ-003 SHALL have parameter IDX_BITS, default $clog2(SETS): set index width.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port clk_i  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port flush_req_i  in  1  request: write back all dirty lines, then invalidate every set.
REQ-007 SHALL have port clean_req_i  in  1  request: write back all dirty lines, keep them valid.
REQ-008 SHALL have port inv_req_i  in  1  request: invalidate every set, discarding dirty data.
REQ-009 SHALL have port dirty_i  in  WAYS  dirty bits of the set addressed by set_idx_o, valid one cycle after the address.
REQ-010 SHALL have port evict_ack_i  in  1  write-back of evict_way_o is complete.
REQ-011 SHALL have port busy_o  out  1  sequencer not IDLE; also used as the core pipeline stall.
REQ-012 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-013 SHALL have port set_idx_o  out  IDX_BITS  set currently being walked.
REQ-014 SHALL have port evict_req_o  out  1  write-back request, held until ack.
REQ-015 SHALL have port evict_way_o  out  WAYS  one-hot way to write back.
REQ-016 SHALL have port inv_set_o  out  1  clear valid and dirty for all ways of set_idx_o this cycle.
REQ-017 SHALL have port clr_dirty_o  out  1  clear dirty for all ways of set_idx_o this cycle.

Function
REQ-018 SHALL implement states IDLE, READ, CHECK, EVICT, UPDATE, DONE.
REQ-019 SHALL sample requests only in IDLE, with priority flush > clean > inv, latch the mode, clear set_idx_o, and leave IDLE on the next edge; requests outside IDLE SHALL be ignored.
REQ-020 Flush and clean modes SHALL go IDLE->READ; inv mode SHALL go IDLE->UPDATE.
REQ-021 READ SHALL last one cycle with set_idx_o presented, then go to CHECK.
REQ-022 CHECK SHALL latch dirty_i into a pending mask; a zero mask SHALL go to UPDATE, otherwise EVICT.
REQ-023 EVICT SHALL assert evict_req_o with evict_way_o set to the lowest pending bit.
REQ-024 Each cycle with evict_ack_i high in EVICT SHALL clear that pending bit; evict_req_o may be acked in its first cycle.
REQ-025 EVICT SHALL go to UPDATE in the cycle after the ack that empties the mask; evict_ack_i SHALL be ignored outside EVICT.
REQ-026 UPDATE SHALL last one cycle, asserting inv_set_o in flush/inv mode or clr_dirty_o in clean mode.
REQ-027 Leaving UPDATE with set_idx_o == SETS-1 SHALL go to DONE; otherwise set_idx_o SHALL increment and the next state SHALL be READ (flush/clean) or UPDATE (inv).
REQ-028 DONE SHALL assert done_o for exactly one cycle, then return to IDLE; set_idx_o SHALL never wrap mid-walk.
REQ-029 busy_o SHALL be high in every state except IDLE, including DONE.
REQ-030 evict_req_o, inv_set_o and clr_dirty_o SHALL be mutually exclusive.

Reset
REQ-031 Asserting rst_ni low SHALL force IDLE at any time, including mid-eviction, abandoning the walk.
REQ-032 While rst_ni is low, busy_o, done_o, evict_req_o, inv_set_o and clr_dirty_o SHALL be 0, and set_idx_o, evict_way_o and the pending mask SHALL be 0.

Configuration
REQ-033 Macro RISCV_CACHE_WRITEBACK_EN defined SHALL enable full flush/clean behaviour as specified.
REQ-034 Without RISCV_CACHE_WRITEBACK_EN: clean_req_i and dirty_i SHALL be ignored, flush_req_i SHALL behave as inv_req_i, evict_req_o/evict_way_o/clr_dirty_o SHALL be tied 0, and READ/CHECK/EVICT SHALL be absent.

Structure
REQ-035 The state enum maint_state_t and mode enum maint_mode_t SHALL live in riscv_cache_pkg.
REQ-036 The lowest-set-bit one-hot function SHALL live in riscv_cache_pkg; there SHALL be no sub-module.

Verification
REQ-037 SETS=4, inv_req_i pulse at cycle 0 -> inv_set_o high cycles 1-4 with set_idx_o 0,1,2,3; done_o at cycle 5; busy_o low at cycle 6.
REQ-038 SETS=4, clean_req_i with dirty_i=0 -> 3 cycles per set, clr_dirty_o once per set, no evict_req_o, done_o at cycle 13.
REQ-039 WAYS=2, flush_req_i, set 1 dirty_i=2'b11 -> evict_way_o 01 until ack, then 10 until ack, then inv_set_o for set 1.
REQ-040 flush_req_i, clean_req_i and inv_req_i together in IDLE -> flush mode; a new inv_req_i while busy -> no effect.
REQ-041 rst_ni low during EVICT with evict_req_o=1 -> all outputs 0 immediately; busy_o low after reset release.
REQ-042 Build without RISCV_CACHE_WRITEBACK_EN, flush_req_i with dirty_i=all ones -> identical to REQ-037, evict_req_o never high.

Source files
------------

// File: rtl/riscv_cache_pkg.sv
// Shared types and helpers for the cache maintenance sequencer (riscv_cache_maint).
// Ways are limited to MAX_WAYS by the width of the lowest-set-bit helper.
package riscv_cache_pkg;

    localparam int MAX_WAYS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_EVICT,
        ST_UPDATE,
        ST_DONE
    } maint_state_t;

    typedef enum logic [1:0] {
        MODE_INV,
        MODE_CLEAN,
        MODE_FLUSH
    } maint_mode_t;

    // Isolate the lowest set bit: v & -v.
    function automatic logic [MAX_WAYS-1:0] lowest_onehot(input logic [MAX_WAYS-1:0] v);
        return v & (~v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/riscv_cache_maint.sv
// Whole-cache maintenance sequencer: walks every set to flush, clean or invalidate.
// Define RISCV_CACHE_WRITEBACK_EN for dirty write-back; otherwise only invalidation exists.
module riscv_cache_maint
    import riscv_cache_pkg::*;
#(
    parameter int SETS     = 32,
    parameter int WAYS     = 2,
    parameter int IDX_BITS = $clog2(SETS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_req_i,
    input  logic                clean_req_i,
    input  logic                inv_req_i,
    input  logic [WAYS-1:0]     dirty_i,
    input  logic                evict_ack_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [IDX_BITS-1:0] set_idx_o,
    output logic                evict_req_o,
    output logic [WAYS-1:0]     evict_way_o,
    output logic                inv_set_o,
    output logic                clr_dirty_o
);

    maint_state_t        state_q, state_d;
    maint_mode_t         mode_q, mode_d;
    logic [IDX_BITS-1:0] set_idx_q, set_idx_d;
    logic                last_set;

    assign last_set  = (set_idx_q == IDX_BITS'(SETS - 1));
    assign set_idx_o = set_idx_q;

`ifdef RISCV_CACHE_WRITEBACK_EN
    logic [WAYS-1:0]     pending_q, pending_d;
    logic [WAYS-1:0]     evict_way;
    logic [MAX_WAYS-1:0] way_full;
    logic                unused_way_hi;

    assign way_full      = lowest_onehot(MAX_WAYS'(pending_q));
    assign evict_way     = way_full[WAYS-1:0];
    assign unused_way_hi = ^way_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clean_req_i, dirty_i, evict_ack_i};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_INV;
            set_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            set_idx_q <= set_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        set_idx_d = set_idx_q;
`ifdef RISCV_CACHE_WRITEBACK_EN
        pending_d = pending_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef RISCV_CACHE_WRITEBACK_EN
                if (flush_req_i) begin
                    mode_d    = MODE_FLUSH;
                    set_idx_d = '0;
                    state_d   = ST_READ;
                end else if (clean_req_i) begin
                    mode_d    = MODE_CLEAN;
                    set_idx_d = '0;
                    state_d   = ST_READ;
                end else if (inv_req_i) begin
                    mode_d    = MODE_INV;
                    set_idx_d = '0;
                    state_d   = ST_UPDATE;
                end
`else
                // Without write-back a flush degenerates to a plain invalidate.
                if (flush_req_i || inv_req_i) begin
                    mode_d    = MODE_INV;
                    set_idx_d = '0;
                    state_d   = ST_UPDATE;
                end
`endif
            end
`ifdef RISCV_CACHE_WRITEBACK_EN
            ST_READ: state_d = ST_CHECK;
            ST_CHECK: begin
                pending_d = dirty_i;
                state_d   = (dirty_i == '0) ? ST_UPDATE : ST_EVICT;
            end
            ST_EVICT: begin
                if (evict_ack_i) begin
                    pending_d = pending_q & ~evict_way;
                    if ((pending_q & ~evict_way) == '0) begin
                        state_d = ST_UPDATE;
                    end
                end
            end
`endif
            ST_UPDATE: begin
                if (last_set) begin
                    state_d = ST_DONE;
                end else begin
                    set_idx_d = set_idx_q + IDX_BITS'(1);
                    state_d   = (mode_q == MODE_INV) ? ST_UPDATE : ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        done_o    = (state_q == ST_DONE);
        inv_set_o = (state_q == ST_UPDATE) && (mode_q != MODE_CLEAN);
`ifdef RISCV_CACHE_WRITEBACK_EN
        evict_req_o = (state_q == ST_EVICT);
        evict_way_o = (state_q == ST_EVICT) ? evict_way : '0;
        clr_dirty_o = (state_q == ST_UPDATE) && (mode_q == MODE_CLEAN);
`else
        evict_req_o = 1'b0;
        evict_way_o = '0;
        clr_dirty_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_riscv_cache_maint.sv
// Randomized bench for riscv_cache_maint against a transaction-level expected-trace model.
module tb_riscv_cache_maint;

    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int IDX  = 2;
    localparam int OW   = 5 + WAYS + IDX;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_req_i = 1'b0;
    logic            clean_req_i = 1'b0;
    logic            inv_req_i = 1'b0;
    logic [WAYS-1:0] dirty_i = '0;
    logic            evict_ack_i = 1'b0;
    logic            busy_o, done_o, evict_req_o, inv_set_o, clr_dirty_o;
    logic [IDX-1:0]  set_idx_o;
    logic [WAYS-1:0] evict_way_o;

    always #5 clk_i = ~clk_i;

    riscv_cache_maint #(.SETS(SETS), .WAYS(WAYS), .IDX_BITS(IDX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .flush_req_i(flush_req_i), .clean_req_i(clean_req_i), .inv_req_i(inv_req_i),
        .dirty_i(dirty_i), .evict_ack_i(evict_ack_i),
        .busy_o(busy_o), .done_o(done_o), .set_idx_o(set_idx_o),
        .evict_req_o(evict_req_o), .evict_way_o(evict_way_o),
        .inv_set_o(inv_set_o), .clr_dirty_o(clr_dirty_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {busy, done, evict_req, inv_set, clr_dirty, evict_way, set_idx}
    function automatic logic [OW-1:0] obs();
        return {busy_o, done_o, evict_req_o, inv_set_o, clr_dirty_o, evict_way_o, set_idx_o};
    endfunction

    function automatic logic [OW-1:0] pack(input bit b, input bit d, input bit e, input bit i,
                                           input bit c, input logic [WAYS-1:0] w, input int idx);
        return {b, d, e, i, c, w, IDX'(idx)};
    endfunction

    logic [WAYS-1:0] mem [SETS];
    int              dly_q[$];
    int              rsp_q[$];
    int              cnt;
    int              last_idx = 0;
    logic [OW-1:0]   exp_q[$];

    // 0 = no operation, 1 = invalidate, 2 = clean, 3 = flush
    function automatic int resolve_mode(input bit f, input bit c, input bit i);
`ifdef RISCV_CACHE_WRITEBACK_EN
        if (f) return 3;
        if (c) return 2;
        if (i) return 1;
        return 0;
`else
        return (f || i) ? 1 : 0;
`endif
    endfunction

    // Expected per-cycle outputs, starting with the cycle after the request edge.
    task automatic build_expected(input int mode);
        int k;
        k = 0;
        exp_q.delete();
        if (mode == 0) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, '0, last_idx));
            exp_q.push_back(pack(0, 0, 0, 0, 0, '0, last_idx));
            return;
        end
        for (int s = 0; s < SETS; s++) begin
            if (mode != 1) begin
                exp_q.push_back(pack(1, 0, 0, 0, 0, '0, s));
                exp_q.push_back(pack(1, 0, 0, 0, 0, '0, s));
                for (int w = 0; w < WAYS; w++) begin
                    if (mem[s][w]) begin
                        for (int d = 0; d <= dly_q[k]; d++)
                            exp_q.push_back(pack(1, 0, 1, 0, 0, WAYS'(1) << w, s));
                        k++;
                    end
                end
            end
            exp_q.push_back(pack(1, 0, 0, mode != 2, mode == 2, '0, s));
        end
        exp_q.push_back(pack(1, 1, 0, 0, 0, '0, SETS - 1));
        exp_q.push_back(pack(0, 0, 0, 0, 0, '0, SETS - 1));
        last_idx = SETS - 1;
    endtask

    // Responder: cache dirty array, ack after the planned delay, junk elsewhere.
    task automatic drive_inputs(input bit quiet);
        dirty_i = mem[set_idx_o];
        if (evict_req_o) begin
            if (rsp_q.size() == 0 || cnt >= rsp_q[0]) begin
                evict_ack_i = 1'b1;
                if (rsp_q.size() != 0) void'(rsp_q.pop_front());
                cnt = 0;
            end else begin
                evict_ack_i = 1'b0;
                cnt++;
            end
        end else begin
            evict_ack_i = 1'($urandom_range(0, 1));
        end
        if (quiet) begin
            {flush_req_i, clean_req_i, inv_req_i} = 3'b000;
        end else begin
            {flush_req_i, clean_req_i, inv_req_i} = 3'($urandom_range(0, 7));
        end
    endtask

    // Called at a falling edge while the DUT is idle; returns at a falling edge in idle.
    task automatic run_txn(input string tag, input bit f, input bit c, input bit i, input int max_dly);
        int mode;
        dly_q.delete();
        for (int n = 0; n < SETS * WAYS; n++) dly_q.push_back($urandom_range(0, max_dly));
        rsp_q = dly_q;
        cnt = 0;
        mode = resolve_mode(f, c, i);
        build_expected(mode);
        flush_req_i = f;
        clean_req_i = c;
        inv_req_i   = i;
        evict_ack_i = 1'b0;
        @(posedge clk_i);
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge clk_i);
            chk($sformatf("%s[%0d]", tag, n), 32'(obs()), 32'(exp_q[n]));
            drive_inputs((n == exp_q.size() - 1) || (mode == 0));
        end
    endtask

    task automatic reset_mid_walk();
        for (int s = 0; s < SETS; s++) mem[s] = '1;
        mem[0] = WAYS'(1);
        flush_req_i = 1'b1;
        evict_ack_i = 1'b0;
        @(posedge clk_i);
`ifdef RISCV_CACHE_WRITEBACK_EN
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i);
            flush_req_i = 1'b0;
            evict_ack_i = 1'b0;
            dirty_i = mem[set_idx_o];
        end
        chk("rst_pre_evict", 32'(evict_req_o), 32'd1);
`else
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_i);
            flush_req_i = 1'b0;
        end
        chk("rst_pre_inv", 32'(inv_set_o), 32'd1);
`endif
        rst_ni = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'd0);
        @(negedge clk_i);
        chk("rst_hold", 32'(obs()), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_release", 32'(obs()), 32'd0);
        last_idx = 0;
    endtask

    initial begin
        logic [2:0] r;
        for (int s = 0; s < SETS; s++) mem[s] = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_state", 32'(obs()), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", 32'(obs()), 32'd0);

        for (int s = 0; s < SETS; s++) mem[s] = WAYS'($urandom);
        run_txn("inv", 1'b0, 1'b0, 1'b1, 0);

        for (int s = 0; s < SETS; s++) mem[s] = '0;
        run_txn("clean_nodirty", 1'b0, 1'b1, 1'b0, 0);

        for (int s = 0; s < SETS; s++) mem[s] = '0;
        mem[1] = '1;
        run_txn("flush_set1", 1'b1, 1'b0, 1'b0, 2);

        for (int s = 0; s < SETS; s++) mem[s] = WAYS'($urandom);
        run_txn("all_three", 1'b1, 1'b1, 1'b1, 3);

        for (int s = 0; s < SETS; s++) mem[s] = '1;
        run_txn("flush_alldirty", 1'b1, 1'b0, 1'b0, 1);

        reset_mid_walk();

        for (int t = 0; t < 40; t++) begin
            for (int s = 0; s < SETS; s++) mem[s] = WAYS'($urandom);
            r = 3'($urandom_range(1, 7));
            run_txn($sformatf("rnd%0d", t), r[2], r[1], r[0], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
